// File: rtl/scoreboard_reg_file_pkg.sv
// Shared constants for the scoreboarded register file.
//   DATA_W_DEF / ADDR_W_DEF / NUM_RD_DEF / PEND_W_DEF : default geometry
//   PC_IDX_DEF, LR_IDX, SP_IDX                        : architectural register indices
package scoreboard_reg_file_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int NUM_RD_DEF = 4;
    localparam int PEND_W_DEF = 2;   // up to 3 writes in flight per register

    localparam int PC_IDX_DEF = 15;
    localparam int LR_IDX     = 14;
    localparam int SP_IDX     = 13;
endpackage

// File: rtl/scoreboard_reg_file_pend.sv
// Saturating pending-write counter for one register.
//   clk, rst_n      : clock, async active-low reset (count -> 0)
//   inc[1:0]        : reservations this cycle (0..2)
//   dec[1:0]        : completions this cycle (0..2)
//   count           : current number of writes in flight
//   busy_after_dec  : writes still outstanding once this cycle's completions land
//   ovf / unf       : single-cycle flags; reservations dropped / excess completions ignored
module pend_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        inc,
    input  logic [1:0]        dec,
    output logic [PEND_W-1:0] count,
    output logic              busy_after_dec,
    output logic              ovf,
    output logic              unf
);
    localparam int              SUM_W = PEND_W + 2;
    localparam logic [SUM_W-1:0] MAX  = SUM_W'((1 << PEND_W) - 1);

    logic [SUM_W-1:0]  cnt_ext;
    logic [SUM_W-1:0]  inc_ext;
    logic [SUM_W-1:0]  dec_ext;
    logic [SUM_W-1:0]  base;
    logic [PEND_W-1:0] count_nxt;

    assign cnt_ext = {2'b00, count};
    assign inc_ext = {{PEND_W{1'b0}}, inc};
    assign dec_ext = {{PEND_W{1'b0}}, dec};

    assign busy_after_dec = cnt_ext > dec_ext;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ovf       = 1'b0;
        unf       = 1'b0;
        base      = cnt_ext + inc_ext;
        count_nxt = '0;
        // Overflow is judged on the net result, so an inc cancelled by a
        // same-cycle dec never trips saturation.
        if (base > dec_ext && (base - dec_ext) > MAX) begin
            ovf  = 1'b1;
            base = cnt_ext;
        end
        if (dec_ext > base) begin
            unf = 1'b1;
        end else begin
            count_nxt = PEND_W'(base - dec_ext);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_nxt;
    end
endmodule

// File: rtl/scoreboard_reg_file.sv
// Register file with per-register pending-write scoreboard for the pipelined core.
//   rd_en/rd_addr -> rd_data/rd_busy : NUM_RD combinational read ports with wb/upd bypass
//   rsv_dst_*, rsv_upd_*             : issue-time reservations (counter increments)
//   wb_*, upd_*                      : write-back / base-update completions (decrements + data)
//   pc_we/pc_next -> pc_out          : sequential PC path, blocked while PC has pending writes
//   stall                            : decode hold; err_ovf/err_unf sticky scoreboard errors
module scoreboard_reg_file
    import scoreboard_reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int PEND_W = PEND_W_DEF,
    parameter int PC_IDX = PC_IDX_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     rsv_dst_vld,
    input  logic [ADDR_W-1:0]        rsv_dst_addr,
    input  logic                     rsv_upd_vld,
    input  logic [ADDR_W-1:0]        rsv_upd_addr,
    input  logic                     wb_vld,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     upd_vld,
    input  logic [ADDR_W-1:0]        upd_addr,
    input  logic [DATA_W-1:0]        upd_data,
    input  logic                     pc_we,
    input  logic [DATA_W-1:0]        pc_next,
    output logic [DATA_W-1:0]        pc_out,
    output logic                     stall,
    output logic                     err_ovf,
    output logic                     err_unf
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]   regs     [NUM_REGS];
    logic [PEND_W-1:0]   pend     [NUM_REGS];
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] upd_hit;
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] ovf_vec;
    logic [NUM_REGS-1:0] unf_vec;
    logic                pc_ok;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(r);
        logic [1:0] inc;
        logic [1:0] dec;

        assign wb_hit[r]  = wb_vld  && (wb_addr  == IDX);
        assign upd_hit[r] = upd_vld && (upd_addr == IDX);
        assign inc = 2'(rsv_dst_vld && (rsv_dst_addr == IDX))
                   + 2'(rsv_upd_vld && (rsv_upd_addr == IDX));
        assign dec = 2'(wb_hit[r]) + 2'(upd_hit[r]);

        pend_counter #(.PEND_W(PEND_W)) u_pend (
            .clk            (clk),
            .rst_n          (rst_n),
            .inc            (inc),
            .dec            (dec),
            .count          (pend[r]),
            .busy_after_dec (busy_reg[r]),
            .ovf            (ovf_vec[r]),
            .unf            (unf_vec[r])
        );
    end

    // A sequential PC step only lands when nothing older still owns the PC.
    assign pc_ok = pc_we && (pend[PC_IDX] == '0) && !wb_hit[PC_IDX] && !upd_hit[PC_IDX];

    // NOTE: the architectural register array is reset because all registers must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wb_hit[r])                  regs[r] <= wb_data;
                else if (upd_hit[r])            regs[r] <= upd_data;
                else if (r == PC_IDX && pc_ok)  regs[r] <= pc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= err_ovf | (|ovf_vec);
            err_unf <= err_unf | (|unf_vec);
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        rd_data = '0;
        rd_busy = '0;
        a       = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a = rd_addr[i*ADDR_W +: ADDR_W];
            if (rd_en[i]) begin
                if (wb_hit[a])       rd_data[i*DATA_W +: DATA_W] = wb_data;
                else if (upd_hit[a]) rd_data[i*DATA_W +: DATA_W] = upd_data;
                else                 rd_data[i*DATA_W +: DATA_W] = regs[a];
                rd_busy[i] = busy_reg[a];
            end
        end
    end

    assign pc_out = regs[PC_IDX];
    assign stall  = (|rd_busy) | (pc_we && (pend[PC_IDX] != '0));
endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Randomized + directed bench for scoreboard_reg_file against an arithmetic reference model.
module tb_scoreboard_reg_file;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 4;
    localparam int NREG = 16;
    localparam int PMAX = 3;
    localparam int PC = 15;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic            rsv_dst_vld, rsv_upd_vld, wb_vld, upd_vld, pc_we;
    logic [AW-1:0]   rsv_dst_addr, rsv_upd_addr, wb_addr, upd_addr;
    logic [DW-1:0]   wb_data, upd_data, pc_next, pc_out;
    logic            stall, err_ovf, err_unf;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] m_reg [NREG];
    int            m_pend [NREG];
    bit            m_ovf, m_unf;

    scoreboard_reg_file dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .rsv_dst_vld(rsv_dst_vld), .rsv_dst_addr(rsv_dst_addr),
        .rsv_upd_vld(rsv_upd_vld), .rsv_upd_addr(rsv_upd_addr),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
        .upd_vld(upd_vld), .upd_addr(upd_addr), .upd_data(upd_data),
        .pc_we(pc_we), .pc_next(pc_next), .pc_out(pc_out),
        .stall(stall), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        rsv_dst_vld = 0; rsv_dst_addr = '0; rsv_upd_vld = 0; rsv_upd_addr = '0;
        wb_vld = 0; wb_addr = '0; wb_data = '0;
        upd_vld = 0; upd_addr = '0; upd_data = '0;
        pc_we = 0; pc_next = '0;
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_en[port] = 1'b1;
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r] = '0;
            m_pend[r] = 0;
        end
        m_ovf = 0;
        m_unf = 0;
    endtask

    function automatic int n_dec(input int a);
        return int'(wb_vld && wb_addr == AW'(a)) + int'(upd_vld && upd_addr == AW'(a));
    endfunction

    function automatic int n_inc(input int a);
        return int'(rsv_dst_vld && rsv_dst_addr == AW'(a)) + int'(rsv_upd_vld && rsv_upd_addr == AW'(a));
    endfunction

    // Compare every output against the model for the inputs currently applied.
    task automatic check_outputs();
        logic [DW-1:0] exp_d;
        bit            exp_b;
        bit            any_busy;
        int            a;
        any_busy = 0;
        for (int i = 0; i < NR; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            exp_d = '0;
            exp_b = 0;
            if (rd_en[i]) begin
                if (wb_vld && wb_addr == AW'(a))        exp_d = wb_data;
                else if (upd_vld && upd_addr == AW'(a)) exp_d = upd_data;
                else                                    exp_d = m_reg[a];
                exp_b = (m_pend[a] - n_dec(a)) > 0;
            end
            any_busy |= exp_b;
            check($sformatf("rd_data%0d", i), rd_data[i*DW +: DW], exp_d);
            check($sformatf("rd_busy%0d", i), DW'(rd_busy[i]), DW'(exp_b));
        end
        check("stall", DW'(stall), DW'(any_busy || (pc_we && m_pend[PC] != 0)));
        check("pc_out", pc_out, m_reg[PC]);
        check("err_ovf", DW'(err_ovf), DW'(m_ovf));
        check("err_unf", DW'(err_unf), DW'(m_unf));
    endtask

    // Advance the model by one clock edge with the inputs currently applied.
    task automatic model_clock();
        logic [DW-1:0] nreg [NREG];
        int inc, dec, net;
        for (int r = 0; r < NREG; r++) begin
            nreg[r] = m_reg[r];
            if (wb_vld && wb_addr == AW'(r))        nreg[r] = wb_data;
            else if (upd_vld && upd_addr == AW'(r)) nreg[r] = upd_data;
            else if (r == PC && pc_we && m_pend[PC] == 0) nreg[r] = pc_next;
        end
        for (int r = 0; r < NREG; r++) begin
            inc = n_inc(r);
            dec = n_dec(r);
            net = m_pend[r] + inc - dec;
            if (net > PMAX) begin
                m_ovf = 1;
                net = m_pend[r] - dec;
            end
            if (net < 0) begin
                m_unf = 1;
                net = 0;
            end
            m_pend[r] = net;
            m_reg[r] = nreg[r];
        end
    endtask

    // Inputs are driven just after a falling edge; check, then cross one rising edge.
    task automatic step();
        #1;
        check_outputs();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_pc", pc_out, '0);
        check("async_reset_unf", DW'(err_unf), '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] r_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        // 1: reset state
        check("rst_pc", pc_out, '0);
        check("rst_stall", DW'(stall), '0);
        check("rst_ovf", DW'(err_ovf), '0);
        check("rst_unf", DW'(err_unf), '0);
        @(negedge clk);
        rst_n = 1'b1;

        wb_vld = 1; wb_addr = 3; wb_data = 32'h1234;
        step();
        idle(); set_rd(0, 3);
        #1 check("t1_r3", rd_data[31:0], 32'h1234);
        step();

        // 2: reserve r5, read busy, then bypassed completion
        idle(); rsv_dst_vld = 1; rsv_dst_addr = 5;
        step();
        idle(); set_rd(0, 5);
        #1 check("t2_busy", DW'(rd_busy[0]), 1);
        check("t2_stall", DW'(stall), 1);
        step();
        idle(); set_rd(0, 5); wb_vld = 1; wb_addr = 5; wb_data = 32'hABCD;
        #1 check("t2_byp", rd_data[31:0], 32'hABCD);
        check("t2_free", DW'(rd_busy[0]), 0);
        check("t2_nostall", DW'(stall), 0);
        step();

        // 3: two reservations of r2, completed one at a time
        idle(); rsv_dst_vld = 1; rsv_dst_addr = 2; step();
        idle(); rsv_upd_vld = 1; rsv_upd_addr = 2; step();
        idle(); wb_vld = 1; wb_addr = 2; wb_data = 32'h22; step();
        idle(); set_rd(1, 2);
        #1 check("t3_still_busy", DW'(rd_busy[1]), 1);
        step();
        idle(); upd_vld = 1; upd_addr = 2; upd_data = 32'h23; step();
        idle(); set_rd(1, 2);
        #1 check("t3_free", DW'(rd_busy[1]), 0);
        check("t3_data", rd_data[63:32], 32'h23);
        step();

        // 4: saturation and underflow on r7
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle(); rsv_dst_vld = 1; rsv_dst_addr = 7; step();
        end
        #1 check("t4_ovf", DW'(err_ovf), 1);
        for (int k = 0; k < 3; k++) begin
            idle(); wb_vld = 1; wb_addr = 7; wb_data = DW'(k); step();
        end
        idle(); set_rd(2, 7);
        #1 check("t4_pend0", DW'(rd_busy[2]), 0);
        check("t4_no_unf", DW'(err_unf), 0);
        step();
        idle(); wb_vld = 1; wb_addr = 7; step();
        idle();
        #1 check("t4_unf", DW'(err_unf), 1);

        // 5: wb and upd hit r1 together
        do_reset();
        idle(); rsv_dst_vld = 1; rsv_dst_addr = 1; rsv_upd_vld = 1; rsv_upd_addr = 1; step();
        idle(); wb_vld = 1; wb_addr = 1; wb_data = 32'h11; upd_vld = 1; upd_addr = 1; upd_data = 32'h22;
        set_rd(3, 1);
        #1 check("t5_byp", rd_data[127:96], 32'h11);
        check("t5_busy", DW'(rd_busy[3]), 0);
        step();
        idle(); set_rd(3, 1);
        #1 check("t5_reg", rd_data[127:96], 32'h11);
        check("t5_pend0", DW'(rd_busy[3]), 0);
        check("t5_no_unf", DW'(err_unf), 0);
        step();

        // 6: PC interlock
        idle(); rsv_dst_vld = 1; rsv_dst_addr = 4'd15; step();
        idle(); pc_we = 1; pc_next = 32'h8;
        #1 check("t6_stall", DW'(stall), 1);
        step();
        idle();
        #1 check("t6_pc_hold", pc_out, 0);
        idle(); wb_vld = 1; wb_addr = 4'd15; wb_data = 32'h40; pc_we = 1; pc_next = 32'h8; step();
        idle();
        #1 check("t6_pc_wb", pc_out, 32'h40);
        idle(); pc_we = 1; pc_next = 32'h44; step();
        idle();
        #1 check("t6_pc_seq", pc_out, 32'h44);
        do_reset();
        idle(); wb_vld = 1; wb_addr = 4; step();
        idle();
        #1 check("t6_unf_after_rst", DW'(err_unf), 1);
        step();

        // Randomized traffic with periodic mid-flight resets
        for (int n = 0; n < 1500; n++) begin
            if (n % 300 == 299) do_reset();
            idle();
            rd_en = NR'($urandom);
            for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = r_addr();
            rsv_dst_vld = ($urandom_range(0, 9) < 3); rsv_dst_addr = r_addr();
            rsv_upd_vld = ($urandom_range(0, 9) < 2); rsv_upd_addr = r_addr();
            wb_vld  = ($urandom_range(0, 9) < 3); wb_addr  = r_addr(); wb_data  = $urandom;
            upd_vld = ($urandom_range(0, 9) < 2); upd_addr = r_addr(); upd_data = $urandom;
            pc_we   = ($urandom_range(0, 9) < 4); pc_next  = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
